// File: rtl/alu_3bit_rr_scheduler.sv
// Round-robin scheduler sharing one combinational 3-bit ALU between two requesters.
// Latency: ready pulse at T, response valid at T+2; one operation every 3 cycles at best.
// Backpressure: a withheld rsp ready holds the response and blocks new acceptances.
module alu_3bit_rr_scheduler #(
  parameter int DATA_W = 3,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [4:0]        rsp0_flags,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [4:0]        rsp1_flags,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [4:0]        alu_flags,

  output logic              busy,
  output logic [CNT_W-1:0]  op0_count,
  output logic [CNT_W-1:0]  op1_count
);

  // IDLE arbitrates, ACCEPT drives the ALU and captures its outputs,
  // EXEC/RESP present the response until the owner takes it.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              state_q,      state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_id_q,   grant_id_d;
  logic [DATA_W-1:0]   op_a_q,       op_a_d;
  logic [DATA_W-1:0]   op_b_q,       op_b_d;
  logic [SEL_W-1:0]    op_sel_q,     op_sel_d;
  logic [DATA_W-1:0]   res_q,        res_d;
  logic [4:0]          flags_q,      flags_d;
  logic [CNT_W-1:0]    op0_cnt_q,    op0_cnt_d;
  logic [CNT_W-1:0]    op1_cnt_q,    op1_cnt_d;

  logic                winner;
  logic                rsp_vld;
  logic                rsp_hs;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Arbitration: on contention the requester not served last time wins;
  // otherwise whichever single requester is valid.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant_q;
    end else begin
      winner = req1_valid;
    end
  end

  // Response is presented from EXEC onward; the handshake may close it in EXEC or RESP.
  always_comb begin
    rsp_vld = (state_q == ST_EXEC) || (state_q == ST_RESP);
    rsp_hs  = rsp_vld && (grant_id_q ? rsp1_ready : rsp0_ready);
  end

  // Next-state, datapath capture and handshake outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sel_d     = op_sel_q;
    res_d        = res_q;
    flags_d      = flags_q;
    op0_cnt_d    = op0_cnt_q;
    op1_cnt_d    = op1_cnt_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~winner;
          req1_ready =  winner;
          grant_id_d = winner;
          op_a_d     = winner ? req1_a   : req0_a;
          op_b_d     = winner ? req1_b   : req0_b;
          op_sel_d   = winner ? req1_sel : req0_sel;
          state_d    = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        // ALU is purely combinational, so its outputs are valid this cycle.
        res_d   = alu_result;
        flags_d = alu_flags;
        state_d = ST_EXEC;
      end
      ST_EXEC, ST_RESP: begin
        if (rsp_hs) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_id_q;
          if (grant_id_q) begin
            if (op1_cnt_q != CNT_MAX) op1_cnt_d = op1_cnt_q + CNT_ONE;
          end else begin
            if (op0_cnt_q != CNT_MAX) op0_cnt_d = op0_cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset drops any in-flight operation and clears counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= '0;
      res_q        <= '0;
      flags_q      <= '0;
      op0_cnt_q    <= '0;
      op1_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sel_q     <= op_sel_d;
      res_q        <= res_d;
      flags_q      <= flags_d;
      op0_cnt_q    <= op0_cnt_d;
      op1_cnt_q    <= op1_cnt_d;
    end
  end

  // ALU drive is quiet in IDLE and holds the latched operation otherwise;
  // responses only appear on the granted requester's channel.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    alu_a       = busy ? op_a_q   : '0;
    alu_b       = busy ? op_b_q   : '0;
    alu_sel     = busy ? op_sel_q : '0;
    rsp0_valid  = rsp_vld && !grant_id_q;
    rsp1_valid  = rsp_vld &&  grant_id_q;
    rsp0_result = rsp0_valid ? res_q   : '0;
    rsp0_flags  = rsp0_valid ? flags_q : '0;
    rsp1_result = rsp1_valid ? res_q   : '0;
    rsp1_flags  = rsp1_valid ? flags_q : '0;
    op0_count   = op0_cnt_q;
    op1_count   = op1_cnt_q;
  end

endmodule

// File: tb/tb_alu_3bit_rr_scheduler.sv
// Directed bench for alu_3bit_rr_scheduler with a behavioural 3-bit ALU attached.
module tb_alu_3bit_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [2:0] rsp0_result, rsp1_result;
  logic [4:0] rsp0_flags, rsp1_flags;
  logic [2:0] alu_a, alu_b, alu_sel, alu_result;
  logic [4:0] alu_flags;
  logic       busy;
  logic [7:0] op0_count, op1_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_3bit_rr_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result), .alu_flags(alu_flags),
    .busy(busy), .op0_count(op0_count), .op1_count(op1_count)
  );

  // Reference ALU: flags = {carry/borrow, zero, a==b, a<b, a>b}.
  always_comb begin
    logic [3:0] wide;
    wide = 4'd0;
    case (alu_sel)
      3'b000: wide = {1'b0, alu_a ^ alu_b};
      3'b001: wide = {1'b0, alu_a} + {1'b0, alu_b};
      3'b010: wide = {1'b0, alu_a} - {1'b0, alu_b};
      3'b011: wide = {1'b0, alu_a & alu_b};
      3'b100: wide = {1'b0, alu_a | alu_b};
      3'b101: wide = {3'b000, alu_a == alu_b};
      3'b110: wide = {3'b000, alu_a <  alu_b};
      default: wide = {3'b000, alu_a > alu_b};
    endcase
    alu_result = wide[2:0];
    alu_flags  = {((alu_sel == 3'b001) || (alu_sel == 3'b010)) ? wide[3] : 1'b0,
                  wide[2:0] == 3'b000, alu_a == alu_b, alu_a < alu_b, alu_a > alu_b};
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_sel = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    cyc(); cyc();
    rst = 1'b0;
    settle();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", {rsp0_valid, rsp1_valid}); end
    total++; if ({alu_a, alu_b, alu_sel} !== 9'd0) begin bad++; $display("FAIL reset_alu_drive got=%h exp=0", {alu_a, alu_b, alu_sel}); end
    total++; if ({op0_count, op1_count} !== 16'd0) begin bad++; $display("FAIL reset_counts got=%h exp=0", {op0_count, op1_count}); end
    total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
  endtask

  // 7 + 1 on req0: result wraps to 000 with carry out.
  task automatic test_single();
    req0_valid = 1; req0_a = 3'b111; req0_b = 3'b001; req0_sel = 3'b001;
    settle();
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
    cyc(); req0_valid = 0; settle();
    total++; if ({alu_a, alu_b, alu_sel} !== {3'b111, 3'b001, 3'b001}) begin bad++; $display("FAIL single_alu_drive got=%h exp=%h", {alu_a, alu_b, alu_sel}, {3'b111, 3'b001, 3'b001}); end
    total++; if ({busy, rsp0_valid} !== 2'b10) begin bad++; $display("FAIL single_accept got=%b exp=10", {busy, rsp0_valid}); end
    cyc(); settle();
    total++; if (rsp0_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid_T2 got=%0b exp=1", rsp0_valid); end
    total++; if (rsp0_result !== 3'b000) begin bad++; $display("FAIL single_result got=%b exp=000", rsp0_result); end
    total++; if (rsp0_flags !== 5'b11001) begin bad++; $display("FAIL single_flags got=%b exp=11001", rsp0_flags); end
    total++; if ({rsp1_valid, rsp1_result, rsp1_flags} !== 9'd0) begin bad++; $display("FAIL single_other_rsp got=%h exp=0", {rsp1_valid, rsp1_result, rsp1_flags}); end
    rsp0_ready = 1;
    cyc(); rsp0_ready = 0; settle();
    total++; if ({busy, op0_count, op1_count} !== {1'b0, 8'd1, 8'd0}) begin bad++; $display("FAIL single_done got=%h exp=%h", {busy, op0_count, op1_count}, {1'b0, 8'd1, 8'd0}); end
    total++; if ({alu_a, alu_b, alu_sel} !== 9'd0) begin bad++; $display("FAIL single_idle_alu got=%h exp=0", {alu_a, alu_b, alu_sel}); end
  endtask

  // Both requesting continuously after reset: grants alternate 0,1,0,1.
  task automatic test_arbitration();
    logic [1:0] exp_rdy;
    logic [2:0] exp_res;
    rst = 1; cyc(); rst = 0;
    req0_valid = 1; req0_a = 3'd1; req0_b = 3'd2; req0_sel = 3'b000;
    req1_valid = 1; req1_a = 3'd3; req1_b = 3'd1; req1_sel = 3'b011;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_res = (i % 2 == 0) ? 3'd3 : 3'd1;
      settle();
      total++; if ({req0_ready, req1_ready} !== exp_rdy) begin bad++; $display("FAIL arb_grant_%0d got=%b exp=%b", i, {req0_ready, req1_ready}, exp_rdy); end
      cyc(); settle();
      total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL arb_no_ready_busy_%0d got=%b exp=00", i, {req0_ready, req1_ready}); end
      cyc(); settle();
      total++; if ({rsp0_valid, rsp1_valid} !== exp_rdy) begin bad++; $display("FAIL arb_rsp_%0d got=%b exp=%b", i, {rsp0_valid, rsp1_valid}, exp_rdy); end
      total++; if ((rsp0_result | rsp1_result) !== exp_res) begin bad++; $display("FAIL arb_result_%0d got=%0d exp=%0d", i, rsp0_result | rsp1_result, exp_res); end
      cyc();
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    settle();
    total++; if ({op0_count, op1_count} !== {8'd2, 8'd2}) begin bad++; $display("FAIL arb_counts got=%h exp=0202", {op0_count, op1_count}); end
  endtask

  // 2 - 2 on req1 with the response held off for 5 cycles; req0 waits.
  task automatic test_backpressure();
    req1_valid = 1; req1_a = 3'b010; req1_b = 3'b010; req1_sel = 3'b010;
    settle();
    total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL bp_grant1 got=%b exp=01", {req0_ready, req1_ready}); end
    cyc(); req1_valid = 0;
    req0_valid = 1; req0_a = 3'd1; req0_b = 3'd1; req0_sel = 3'b001;
    cyc(); settle();
    total++; if ({rsp1_valid, rsp1_result, rsp1_flags} !== {1'b1, 3'b000, 5'b01100}) begin bad++; $display("FAIL bp_rsp1 got=%h exp=%h", {rsp1_valid, rsp1_result, rsp1_flags}, {1'b1, 3'b000, 5'b01100}); end
    for (int k = 0; k < 5; k++) begin
      cyc(); settle();
      total++; if ({rsp1_valid, rsp1_result, rsp1_flags, req0_ready, busy} !== {1'b1, 3'b000, 5'b01100, 1'b0, 1'b1}) begin
        bad++; $display("FAIL bp_hold_%0d got=%h exp=%h", k, {rsp1_valid, rsp1_result, rsp1_flags, req0_ready, busy}, {1'b1, 3'b000, 5'b01100, 1'b0, 1'b1});
      end
    end
    rsp1_ready = 1;
    #1;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL bp_no_ready_at_hs got=%0b exp=0", req0_ready); end
    cyc(); rsp1_ready = 0; settle();
    total++; if ({req0_ready, op1_count} !== {1'b1, 8'd3}) begin bad++; $display("FAIL bp_after_hs got=%h exp=%h", {req0_ready, op1_count}, {1'b1, 8'd3}); end
    cyc(); req0_valid = 0;
    cyc(); settle();
    total++; if ({rsp0_valid, rsp0_result} !== {1'b1, 3'd2}) begin bad++; $display("FAIL bp_req0_rsp got=%h exp=%h", {rsp0_valid, rsp0_result}, {1'b1, 3'd2}); end
    rsp0_ready = 1;
    cyc(); rsp0_ready = 0; settle();
    total++; if ({busy, op0_count} !== {1'b0, 8'd3}) begin bad++; $display("FAIL bp_req0_done got=%h exp=%h", {busy, op0_count}, {1'b0, 8'd3}); end
  endtask

  // Reset while req0's 6 > 1 response is presented: operation dropped.
  task automatic test_reset_mid();
    req0_valid = 1; req0_a = 3'b110; req0_b = 3'b001; req0_sel = 3'b111;
    settle();
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%0b exp=1", req0_ready); end
    cyc(); req0_valid = 0;
    cyc(); settle();
    total++; if ({rsp0_valid, rsp0_result, rsp0_flags} !== {1'b1, 3'b001, 5'b00001}) begin bad++; $display("FAIL rm_exec got=%h exp=%h", {rsp0_valid, rsp0_result, rsp0_flags}, {1'b1, 3'b001, 5'b00001}); end
    rst = 1;
    cyc(); settle();
    total++; if ({busy, rsp0_valid, op0_count, op1_count} !== 18'd0) begin bad++; $display("FAIL rm_after_reset got=%h exp=0", {busy, rsp0_valid, op0_count, op1_count}); end
    rst = 0;
    cyc(); settle();
    total++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin bad++; $display("FAIL rm_stays_idle got=%b exp=000", {busy, rsp0_valid, rsp1_valid}); end
  endtask

  // 260 back-to-back ADDs (3+4) on req1: counter saturates at 255.
  task automatic test_saturation();
    int done = 0;
    int viol = 0;
    int bad_res = 0;
    logic pending = 0;
    req1_valid = 1; req1_a = 3'd3; req1_b = 3'd4; req1_sel = 3'b001;
    rsp1_ready = 1;
    for (int n = 0; n < 1200 && done < 260; n++) begin
      settle();
      if (req1_ready) pending = 1;
      if (rsp1_valid) begin
        if (!pending) viol++;
        if (rsp1_result !== 3'd7) bad_res++;
        if (rsp1_ready) begin done++; pending = 0; end
      end
      cyc();
    end
    req1_valid = 0; rsp1_ready = 0;
    settle();
    total++; if (done !== 260) begin bad++; $display("FAIL sat_ops_completed got=%0d exp=260", done); end
    total++; if (op1_count !== 8'd255) begin bad++; $display("FAIL sat_count got=%0d exp=255", op1_count); end
    total++; if (op0_count !== 8'd0) begin bad++; $display("FAIL sat_count0 got=%0d exp=0", op0_count); end
    total++; if (viol !== 0) begin bad++; $display("FAIL sat_rsp_without_ready got=%0d exp=0", viol); end
    total++; if (bad_res !== 0) begin bad++; $display("FAIL sat_results got=%0d exp=0", bad_res); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
